// File: rtl/elevator_scheduler.sv
// Three-floor elevator request scheduler: latches cabin and hall calls, serves
// them in SCAN order and drives registered motor/door outputs.
module elevator_scheduler #(
  parameter int DOOR_CYCLES   = 8,
  parameter int TRAVEL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:1] in_req,
  input  logic [3:1] out_req,
  output logic [1:0] motor,
  output logic       door_open,
  output logic [3:1] current_floor,
  output logic [3:1] pending,
  output logic       busy
);

  localparam int TW = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TravelLast = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DoorLast   = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_e;

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic [3:1]    floor_q, floor_d;
  logic [3:1]    pending_q, pending_d;
  logic [TW-1:0] travelCnt_q, travelCnt_d;
  logic [DW-1:0] doorCnt_q, doorCnt_d;
  logic [1:0]    motor_q;
  logic          doorOpen_q;
  logic          busy_q;

  logic [3:1] press;
  logic [3:1] setMask;
  logic [3:1] clrMask;
  logic       floorPress;

  function automatic logic [3:1] aboveOf(input logic [3:1] f);
    return {f[1] | f[2], f[1], 1'b0};
  endfunction

  function automatic logic [3:1] belowOf(input logic [3:1] f);
    return {1'b0, f[3], f[3] | f[2]};
  endfunction

  // Next-state decisions all look at the registered pending set, so a call that
  // lands on the same edge the car arrives is not treated as a stop.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    floor_d     = floor_q;
    travelCnt_d = '0;
    doorCnt_d   = '0;
    press       = enable ? (in_req | out_req) : 3'b000;
    floorPress  = (state_q == DOOR) && ((press & floor_q) != 3'b000);
    setMask     = press & ~((state_q == DOOR) ? floor_q : 3'b000);

    case (state_q)
      IDLE: begin
        if ((pending_q & floor_q) != 3'b000) begin
          state_d = DOOR;
        end else if ((pending_q & aboveOf(floor_q)) != 3'b000 &&
                     (pending_q & belowOf(floor_q)) != 3'b000) begin
          state_d = dir_q ? MOVE_UP : MOVE_DOWN;
        end else if ((pending_q & aboveOf(floor_q)) != 3'b000) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
        end else if ((pending_q & belowOf(floor_q)) != 3'b000) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end
      MOVE_UP: begin
        if (travelCnt_q == TravelLast) begin
          if (!floor_q[3]) floor_d = {floor_q[2:1], 1'b0};
          if ((pending_q & floor_d) != 3'b000)               state_d = DOOR;
          else if ((pending_q & aboveOf(floor_d)) != 3'b000) state_d = MOVE_UP;
          else                                               state_d = IDLE;
        end else begin
          travelCnt_d = travelCnt_q + 1'b1;
        end
      end
      MOVE_DOWN: begin
        if (travelCnt_q == TravelLast) begin
          if (!floor_q[1]) floor_d = {1'b0, floor_q[3:2]};
          if ((pending_q & floor_d) != 3'b000)               state_d = DOOR;
          else if ((pending_q & belowOf(floor_d)) != 3'b000) state_d = MOVE_DOWN;
          else                                               state_d = IDLE;
        end else begin
          travelCnt_d = travelCnt_q + 1'b1;
        end
      end
      DOOR: begin
        if (floorPress)                  doorCnt_d = '0;
        else if (doorCnt_q == DoorLast)  state_d   = IDLE;
        else                             doorCnt_d = doorCnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    clrMask   = (state_q != DOOR && state_d == DOOR) ? floor_d : 3'b000;
    pending_d = (pending_q | setMask) & ~clrMask;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b1;
      floor_q     <= 3'b001;
      pending_q   <= 3'b000;
      travelCnt_q <= '0;
      doorCnt_q   <= '0;
      motor_q     <= 2'b00;
      doorOpen_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      floor_q     <= floor_d;
      pending_q   <= pending_d;
      travelCnt_q <= travelCnt_d;
      doorCnt_q   <= doorCnt_d;
      motor_q     <= (state_d == MOVE_UP)   ? 2'b01 :
                     (state_d == MOVE_DOWN) ? 2'b10 : 2'b00;
      doorOpen_q  <= (state_d == DOOR);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign motor         = motor_q;
  assign door_open     = doorOpen_q;
  assign current_floor = floor_q;
  assign pending       = pending_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: expected output segments (value + duration) are queued with
// each stimulus and compared as the DUT's observed outputs change.
module tb_elevator_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:1] in_req;
  logic [3:1] out_req;
  logic [1:0] motor;
  logic       door_open;
  logic [3:1] current_floor;
  logic [3:1] pending;
  logic       busy;

  elevator_scheduler #(
    .DOOR_CYCLES  (4),
    .TRAVEL_CYCLES(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_req       (in_req),
    .out_req      (out_req),
    .motor        (motor),
    .door_open    (door_open),
    .current_floor(current_floor),
    .pending      (pending),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string  tag;
    bit [9:0] vec;
    int     len;
  } seg_t;

  seg_t     expQ[$];
  int       compareCount  = 0;
  int       mismatchCount = 0;
  bit       monOn    = 1'b0;
  bit       haveSeg  = 1'b0;
  bit [9:0] curVec;
  int       curLen;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Length 0 marks an open-ended idle segment whose duration the bench controls.
  task automatic pushSeg(input string tag, input bit [1:0] m, input bit d,
                         input bit [2:0] f, input bit [2:0] p, input bit b,
                         input int len);
    seg_t s;
    s.tag = tag;
    s.vec = {m, d, f, p, b};
    s.len = len;
    expQ.push_back(s);
  endtask

  task automatic closeSegment();
    seg_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected-segment", {22'd0, curVec}, 32'h3ff);
    end else begin
      e = expQ.pop_front();
      checkOutput({e.tag, ".value"}, {22'd0, curVec}, {22'd0, e.vec});
      if (e.len > 0) checkOutput({e.tag, ".cycles"}, curLen, e.len);
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (!haveSeg) begin
        curVec  = {motor, door_open, current_floor, pending, busy};
        curLen  = 1;
        haveSeg = 1'b1;
      end else if ({motor, door_open, current_floor, pending, busy} == curVec) begin
        curLen++;
      end else begin
        closeSegment();
        curVec = {motor, door_open, current_floor, pending, busy};
        curLen = 1;
      end
    end
  end

  // Drives one request cycle starting at the current negedge.
  task automatic applyStimulus(input bit en, input bit [2:0] inr, input bit [2:0] outr);
    enable  = en;
    in_req  = inr;
    out_req = outr;
    @(negedge clk);
    enable  = 1'b1;
    in_req  = 3'b000;
    out_req = 3'b000;
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    in_req  = 3'b000;
    out_req = 3'b000;

    pushSeg("reset", 2'b00, 1'b0, 3'b001, 3'b000, 1'b0, 0);
    repeat (3) @(posedge clk);
    monOn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Disabled presses are dropped; enabled 111 serves floor 1 first then climbs.
    pushSeg("en.latch",   2'b00, 1'b0, 3'b001, 3'b111, 1'b0, 1);
    pushSeg("en.door1",   2'b00, 1'b1, 3'b001, 3'b110, 1'b1, 4);
    pushSeg("en.idle1",   2'b00, 1'b0, 3'b001, 3'b110, 1'b0, 1);
    pushSeg("en.up12",    2'b01, 1'b0, 3'b001, 3'b110, 1'b1, 3);
    pushSeg("en.door2",   2'b00, 1'b1, 3'b010, 3'b100, 1'b1, 4);
    pushSeg("en.idle2",   2'b00, 1'b0, 3'b010, 3'b100, 1'b0, 1);
    pushSeg("en.up23",    2'b01, 1'b0, 3'b010, 3'b100, 1'b1, 3);
    pushSeg("en.door3",   2'b00, 1'b1, 3'b100, 3'b000, 1'b1, 4);
    pushSeg("en.idle3",   2'b00, 1'b0, 3'b100, 3'b000, 1'b0, 0);
    applyStimulus(1'b0, 3'b111, 3'b000);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 3'b111, 3'b000);
    repeat (40) @(negedge clk);

    pushSeg("rst.floor3", 2'b00, 1'b0, 3'b001, 3'b000, 1'b0, 0);
    resetPulse();
    repeat (3) @(negedge clk);

    // Reset two cycles into an upward move.
    pushSeg("mr.latch",   2'b00, 1'b0, 3'b001, 3'b100, 1'b0, 1);
    pushSeg("mr.up",      2'b01, 1'b0, 3'b001, 3'b100, 1'b1, 2);
    pushSeg("mr.reset",   2'b00, 1'b0, 3'b001, 3'b000, 1'b0, 0);
    applyStimulus(1'b1, 3'b100, 3'b000);
    repeat (2) @(negedge clk);
    resetPulse();
    repeat (5) @(negedge clk);

    // Continuous two-floor climb, no stop at floor 2.
    pushSeg("s1.latch",   2'b00, 1'b0, 3'b001, 3'b100, 1'b0, 1);
    pushSeg("s1.up12",    2'b01, 1'b0, 3'b001, 3'b100, 1'b1, 3);
    pushSeg("s1.up23",    2'b01, 1'b0, 3'b010, 3'b100, 1'b1, 3);
    pushSeg("s1.door3",   2'b00, 1'b1, 3'b100, 3'b000, 1'b1, 4);
    pushSeg("s1.idle",    2'b00, 1'b0, 3'b100, 3'b000, 1'b0, 0);
    applyStimulus(1'b1, 3'b100, 3'b000);
    repeat (40) @(negedge clk);

    pushSeg("rst.again",  2'b00, 1'b0, 3'b001, 3'b000, 1'b0, 0);
    resetPulse();
    repeat (3) @(negedge clk);

    pushSeg("to2.latch",  2'b00, 1'b0, 3'b001, 3'b010, 1'b0, 1);
    pushSeg("to2.up",     2'b01, 1'b0, 3'b001, 3'b010, 1'b1, 3);
    pushSeg("to2.door",   2'b00, 1'b1, 3'b010, 3'b000, 1'b1, 4);
    pushSeg("to2.idle",   2'b00, 1'b0, 3'b010, 3'b000, 1'b0, 0);
    applyStimulus(1'b1, 3'b010, 3'b000);
    repeat (40) @(negedge clk);

    // Calls on both sides with dir up: go up first, then sweep down past floor 2.
    pushSeg("scan.latch", 2'b00, 1'b0, 3'b010, 3'b101, 1'b0, 1);
    pushSeg("scan.up",    2'b01, 1'b0, 3'b010, 3'b101, 1'b1, 3);
    pushSeg("scan.door3", 2'b00, 1'b1, 3'b100, 3'b001, 1'b1, 4);
    pushSeg("scan.idle",  2'b00, 1'b0, 3'b100, 3'b001, 1'b0, 1);
    pushSeg("scan.dn32",  2'b10, 1'b0, 3'b100, 3'b001, 1'b1, 3);
    pushSeg("scan.dn21",  2'b10, 1'b0, 3'b010, 3'b001, 1'b1, 3);
    pushSeg("scan.door1", 2'b00, 1'b1, 3'b001, 3'b000, 1'b1, 4);
    pushSeg("scan.end",   2'b00, 1'b0, 3'b001, 3'b000, 1'b0, 0);
    applyStimulus(1'b1, 3'b000, 3'b101);
    repeat (40) @(negedge clk);

    // Same-floor press during the door hold restarts the door timer.
    pushSeg("ext.latch",  2'b00, 1'b0, 3'b001, 3'b001, 1'b0, 1);
    pushSeg("ext.door",   2'b00, 1'b1, 3'b001, 3'b000, 1'b1, 7);
    pushSeg("ext.idle",   2'b00, 1'b0, 3'b001, 3'b000, 1'b0, 0);
    applyStimulus(1'b1, 3'b000, 3'b001);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 3'b000, 3'b001);
    repeat (30) @(negedge clk);

    @(posedge clk);
    monOn = 1'b0;
    if (haveSeg) closeSegment();
    checkOutput("leftover-expected", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler and motion sequencer for the three-floor elevator. It latches cabin (in-door) and hall (out-door) floor requests and serves them in SCAN order: it keeps moving in the current direction while requests remain ahead. It drives the motor command and door output, and tracks the current floor. It sits between the login-gated button signals and the motor/door outputs of the elevator top level.

## Interface
- DOOR_CYCLES, 8: cycles the door stays open per stop (≥2)
- TRAVEL_CYCLES, 16: cycles of motor run per floor-to-floor move (≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  request acceptance; connect to the login-granted signal
- in_req  in  [3:1]  cabin floor buttons, one bit per floor, level-sampled each edge
- out_req  in  [3:1]  hall call buttons, one bit per floor
- motor  out  [1:0]  00 stop, 01 up, 10 down; 11 never driven
- door_open  out  1  door open
- current_floor  out  [3:1]  one-hot floor position
- pending  out  [3:1]  latched, unserved requests
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. Internal `dir` register: 1 = up, 0 = down.
- Reset values:
  - state IDLE, dir up, motor 00, door_open 0.
  - current_floor 001, pending 000, busy 0, both counters 0.
- Request latch:
  - At each edge, pending[i] is set if enable & (in_req[i] | out_req[i]), with one exception below.
  - While enable is 0, new presses are dropped; existing pending bits are kept.
  - The exception: a press for the current floor while in DOOR is not latched. It restarts the door counter instead.
  - pending[i] clears on the edge that enters DOOR at floor i. Clear wins over a same-edge set for that floor.
- IDLE, evaluated on registered pending:
  - pending & current_floor ≠ 0 → DOOR.
  - Otherwise, requests both above and below: go in `dir`.
  - Otherwise, only above → MOVE_UP, dir := 1.
  - Otherwise, only below → MOVE_DOWN, dir := 0.
  - Otherwise, stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - motor is 01 or 10 respectively.
  - The travel counter starts at 0 on entry and increments each cycle.
  - At count = TRAVEL_CYCLES−1, current_floor shifts one position (left for up, right for down) and the counter clears.
  - The next state on that edge uses registered pending against the new floor f:
    - pending[f] → DOOR.
    - Otherwise, a request beyond f in the same direction → stay in the same MOVE state.
    - Otherwise → IDLE.
- DOOR:
  - door_open = 1, motor = 00.
  - The door counter increments each cycle. At count = DOOR_CYCLES−1 the next state is IDLE.
  - A qualifying press at the current floor (enable = 1) resets the counter to 0.
- Hard limits: MOVE_UP never leaves floor 3 and MOVE_DOWN never leaves floor 1. The next-state logic guarantees this; the RTL must also gate the shift.
- motor, door_open and busy are decoded from the registered state, so all outputs are glitch-free registered functions.

## Timing
- A press sampled at edge k shows in pending after edge k.
- The move decision is made at edge k+1, so motor is non-zero in the cycle after edge k+1.
- Latency from press to motor start is 2 edges. For a press at the current floor, latency to door_open is also 2 edges.
- Each floor move lasts exactly TRAVEL_CYCLES cycles of non-zero motor. current_floor updates on the same edge the move completes.
- A DOOR stop lasts exactly DOOR_CYCLES cycles, plus any extensions.
- After leaving DOOR, IDLE lasts at least 1 cycle.
- A multi-floor move in one direction runs continuously: motor has no 00 cycle at the intermediate floor.
- A request for floor f that arrives on the same edge the car reaches f is not a stop. If requests remain beyond f the car passes; otherwise it goes IDLE, then DOOR.
- Reset asserted mid-move or mid-door: on the next edge all registers return to their reset values, including current_floor 001 and pending cleared.

## Test plan
All scenarios use DOOR_CYCLES=4, TRAVEL_CYCLES=3.
- Reset → motor 00, door_open 0, current_floor 001, pending 000, busy 0, held for 5 cycles with no input.
- At floor 1, enable=1, in_req=100 for 1 cycle:
  - pending 100 after 1 edge; motor 01 for 6 consecutive cycles.
  - current_floor 010 after cycle 3, then 100 after cycle 6.
  - door_open for 4 cycles, pending 000, then IDLE, busy 0.
- Car at floor 2, dir up, out_req=101 on the same edge → MOVE_UP first. Door opens at floor 3, then MOVE_DOWN for 6 cycles, then door opens at floor 1.
- enable=0 with in_req=111 pulsed → pending stays 000 and motor stays 00. Re-pulse with enable=1 → pending 110 (floor 1 served immediately via DOOR).
- In DOOR at floor 1, out_req=001 pulsed at door count 2 → door_open lasts 4 more cycles (7 total) and pending stays 000.
- rst asserted 2 cycles into MOVE_UP → next edge gives motor 00, current_floor 001, pending 000, state IDLE.
